// File: rtl/pio_pkg.sv
// Shared types and helpers for the banked PIO peripheral: register map,
// edge-capture polarity and byte-lane mask expansion.
package pio_pkg;

    typedef enum logic [2:0] {
        REG_DATA_OUT = 3'd0,
        REG_DATA_IN  = 3'd1,
        REG_DIR      = 3'd2,
        REG_EDGE     = 3'd3,
        REG_IRQ_MASK = 3'd4,
        REG_OUT_SET  = 3'd5,
        REG_OUT_CLR  = 3'd6,
        REG_RSVD     = 3'd7
    } pio_reg_e;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

    // Widest bus the helper supports; callers truncate to their own BUS_WIDTH.
    localparam int MAX_BUS_W = 256;
    localparam int MAX_BE_W  = MAX_BUS_W / 8;

    function automatic logic [MAX_BUS_W-1:0] byte_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_BUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pio_edge_detect.sv
// Two-flop synchroniser for asynchronous pins followed by a history flop;
// emits a one-cycle edge pulse per bit according to EDGE_MODE.
module pio_edge_detect
    import pio_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter edge_mode_t EDGE_MODE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    always_comb begin
        if (EDGE_MODE == EDGE_RISE) begin
            edge_o = sync_q & ~hist_q;
        end else if (EDGE_MODE == EDGE_FALL) begin
            edge_o = ~sync_q & hist_q;
        end else begin
            edge_o = sync_q ^ hist_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pio_irq_banked.sv
// Avalon-MM banked parallel I/O: register bank, word/byte-lane decode,
// registered readback and a level interrupt from masked captured edges.
module pio_irq_banked
    import pio_pkg::*;
#(
    parameter int         PORT_WIDTH = 32,
    parameter int         BUS_WIDTH  = 16,
    parameter edge_mode_t EDGE_MODE  = EDGE_RISE,
    localparam int        NWORDS     = (PORT_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int        WIDX_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int        ADDR_W     = 3 + WIDX_W,
    localparam int        BE_W       = BUS_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [BE_W-1:0]       avs_byteenable,
    input  logic                  avs_write_n,
    input  logic [BUS_WIDTH-1:0]  avs_writedata,
    input  logic                  avs_chipselect,
    input  logic                  avs_read_n,
    output logic [BUS_WIDTH-1:0]  avs_readdata,
    input  logic [PORT_WIDTH-1:0] coe_in_port,
    output logic [PORT_WIDTH-1:0] co_out_port,
    output logic [PORT_WIDTH-1:0] co_oe,
    output logic                  ins_irq
);

    localparam int PAD_W = NWORDS * BUS_WIDTH;

    logic [PORT_WIDTH-1:0] data_out_q, data_out_d;
    logic [PORT_WIDTH-1:0] dir_q, dir_d;
    logic [PORT_WIDTH-1:0] edge_q, edge_d;
    logic [PORT_WIDTH-1:0] mask_q, mask_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic [PORT_WIDTH-1:0] sync_val;
    logic [PORT_WIDTH-1:0] edge_pulse;

    logic                  wr_en;
    logic                  rd_en;
    pio_reg_e              reg_sel;
    logic [WIDX_W-1:0]     word_idx;

    logic [MAX_BE_W-1:0]   be_ext;
    logic [BUS_WIDTH-1:0]  lane_mask;
    logic [PAD_W-1:0]      wmask_pad;
    logic [PAD_W-1:0]      wdata_pad;
    logic [PORT_WIDTH-1:0] wmask;
    logic [PORT_WIDTH-1:0] wbits;
    logic [PORT_WIDTH-1:0] clr_bits;
    logic [PORT_WIDTH-1:0] rd_sel;
    logic [PAD_W-1:0]      rd_pad;
    logic [BUS_WIDTH-1:0]  rd_word;

    pio_edge_detect #(
        .WIDTH     (PORT_WIDTH),
        .EDGE_MODE (EDGE_MODE)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .pin_i  (coe_in_port),
        .sync_o (sync_val),
        .edge_o (edge_pulse)
    );

    assign wr_en    = avs_chipselect & ~avs_write_n;
    assign rd_en    = avs_chipselect & ~avs_read_n;
    assign reg_sel  = pio_reg_e'(avs_address[ADDR_W-1 -: 3]);
    assign word_idx = avs_address[WIDX_W-1:0];

    // Spread the addressed word's lanes onto port bit positions; an out-of-range
    // word matches no slot, so the mask is empty and writes have no effect.
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        be_ext              = '0;
        be_ext[BE_W-1:0]    = avs_byteenable;
        lane_mask           = BUS_WIDTH'(byte_mask(be_ext));
        wmask_pad           = '0;
        wdata_pad           = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (word_idx == WIDX_W'(w)) begin
                wmask_pad[w*BUS_WIDTH +: BUS_WIDTH] = lane_mask;
                wdata_pad[w*BUS_WIDTH +: BUS_WIDTH] = avs_writedata;
            end
        end
        wmask = PORT_WIDTH'(wmask_pad);
        wbits = PORT_WIDTH'(wdata_pad) & wmask;
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr_bits   = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_DATA_OUT: data_out_d = (data_out_q & ~wmask) | wbits;
                REG_OUT_SET:  data_out_d = data_out_q | wbits;
                REG_OUT_CLR:  data_out_d = data_out_q & ~wbits;
                REG_DIR:      dir_d      = (dir_q & ~wmask) | wbits;
                REG_IRQ_MASK: mask_d     = (mask_q & ~wmask) | wbits;
                REG_EDGE:     clr_bits   = wbits;
                default:      ;
            endcase
        end
        // A fresh edge in the same cycle as its W1C wins over the clear.
        edge_d = (edge_q & ~clr_bits) | edge_pulse;
        irq_d  = |(edge_q & mask_q);
    end

    always_comb begin
        case (reg_sel)
            REG_DATA_OUT,
            REG_OUT_SET,
            REG_OUT_CLR:  rd_sel = data_out_q;
            REG_DATA_IN:  rd_sel = sync_val;
            REG_DIR:      rd_sel = dir_q;
            REG_EDGE:     rd_sel = edge_q;
            REG_IRQ_MASK: rd_sel = mask_q;
            default:      rd_sel = '0;
        endcase
        rd_pad  = PAD_W'(rd_sel);
        rd_word = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (word_idx == WIDX_W'(w)) begin
                rd_word = rd_pad[w*BUS_WIDTH +: BUS_WIDTH];
            end
        end
        rdata_d = rd_en ? rd_word : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            dir_q      <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign co_out_port  = data_out_q;
    assign co_oe        = dir_q;
    assign ins_irq      = irq_q;
    assign avs_readdata = rdata_q;

endmodule
